// File: rtl/spram_access_ctrl.sv
// Request/response front end for a single-port RAM with a fixed read latency.
// Reads are credit-limited so every returning word always has room in the response FIFO.
module spram_access_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RSP_DEPTH    = 4
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_rst,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
        $fatal(1, "spram_access_ctrl: READ_LATENCY must be 1 or 2");
    end
    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth_pow2
        $fatal(1, "spram_access_ctrl: RSP_DEPTH must be a power of 2");
    end
    if (RSP_DEPTH < READ_LATENCY + 1) begin : g_bad_depth_min
        $fatal(1, "spram_access_ctrl: RSP_DEPTH must be >= READ_LATENCY+1");
    end

    logic                    fire;
    logic                    rd_fire;
    logic                    push;
    logic                    pop;
    logic [READ_LATENCY-1:0] tag_q;
    logic [READ_LATENCY-1:0] tag_d;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [CW-1:0]           fifo_cnt_q;
    logic [CW-1:0]           fifo_cnt_d;
    logic [CW-1:0]           outstanding_q;
    logic [CW-1:0]           outstanding_d;
    logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];

    // Credits cover both the latency pipe and the FIFO, so a push never finds it full.
    assign req_ready = rsta_n && (outstanding_q < DEPTH_C);
    assign fire      = req_valid & req_ready;
    assign rd_fire   = fire & ~req_we;

    assign mem_en   = fire;
    assign mem_we   = fire & req_we;
    assign mem_addr = req_addr;
    assign mem_din  = req_wdata;
    assign mem_rst  = 1'b0;

    assign push      = tag_q[READ_LATENCY-1];
    assign rsp_valid = (fifo_cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr_q];
    assign busy      = (outstanding_q != '0);

    if (READ_LATENCY > 1) begin : g_tag_shift
        assign tag_d = {tag_q[READ_LATENCY-2:0], rd_fire};
    end else begin : g_tag_single
        assign tag_d = rd_fire;
    end

    always_comb begin
        fifo_cnt_d    = fifo_cnt_q + CW'(push) - CW'(pop);
        outstanding_d = outstanding_q + CW'(rd_fire) - CW'(pop);
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
        end else begin
            tag_q         <= tag_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Data storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clka) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_dout;
        end
    end

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Directed bench: one controller with READ_LATENCY=1 and one with READ_LATENCY=2,
// each attached to a read-first RAM model with the matching latency.
module tb_spram_access_ctrl;

    localparam int AW = 10;
    localparam int DW = 16;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic rsta_n;
    logic load;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic          v1, we1, rr1, rdy1, rv1, busy1, en1, mwe1, mrst1;
    logic [AW-1:0] a1, maddr1;
    logic [DW-1:0] wd1, rd1, din1, dout1;
    logic          v2, we2, rr2, rdy2, rv2, busy2, en2, mwe2, mrst2;
    logic [AW-1:0] a2, maddr2;
    logic [DW-1:0] wd2, rd2, din2, dout2, d2a;
    logic [DW-1:0] ram1 [1024];
    logic [DW-1:0] ram2 [1024];

    spram_access_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RSP_DEPTH(4)
    ) u_dut1 (
        .clka(clka), .rsta_n(rsta_n), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
        .req_addr(a1), .req_wdata(wd1), .rsp_valid(rv1), .rsp_ready(rr1), .rsp_rdata(rd1),
        .busy(busy1), .mem_en(en1), .mem_we(mwe1), .mem_addr(maddr1), .mem_din(din1),
        .mem_rst(mrst1), .mem_dout(dout1)
    );

    spram_access_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .RSP_DEPTH(4)
    ) u_dut2 (
        .clka(clka), .rsta_n(rsta_n), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
        .req_addr(a2), .req_wdata(wd2), .rsp_valid(rv2), .rsp_ready(rr2), .rsp_rdata(rd2),
        .busy(busy2), .mem_en(en2), .mem_we(mwe2), .mem_addr(maddr2), .mem_din(din2),
        .mem_rst(mrst2), .mem_dout(dout2)
    );

    // Read-first RAM, one-cycle latency
    always @(posedge clka) begin
        if (load) begin
            for (int i = 0; i < 8; i++) ram1[i] <= DW'(i);
        end else if (en1) begin
            if (mwe1) ram1[maddr1] <= din1;
            dout1 <= ram1[maddr1];
        end
    end

    // Read-first RAM with an output register, two-cycle latency
    always @(posedge clka) begin
        if (load) begin
            ram2[5] <= 16'h003C;
        end else if (en2) begin
            if (mwe2) ram2[maddr2] <= din2;
            d2a <= ram2[maddr2];
        end
        dout2 <= d2a;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv1(input logic v, input logic we, input int a, input int wd, input logic rr);
        @(negedge clka);
        v1 = v; we1 = we; a1 = AW'(a); wd1 = DW'(wd); rr1 = rr;
        #1;
    endtask

    task automatic drv2(input logic v, input logic we, input int a, input int wd, input logic rr);
        @(negedge clka);
        v2 = v; we2 = we; a2 = AW'(a); wd2 = DW'(wd); rr2 = rr;
        #1;
    endtask

    initial begin
        rsta_n = 1'b0; load = 1'b1;
        v1 = 1'b1; we1 = 1'b1; a1 = '0; wd1 = '0; rr1 = 1'b1;
        v2 = 1'b1; we2 = 1'b0; a2 = '0; wd2 = '0; rr2 = 1'b1;

        // Reset state, with requests presented
        @(negedge clka);
        @(negedge clka);
        load = 1'b0;
        #1;
        chk("rst_ready1", rdy1, 1'b0);
        chk("rst_valid1", rv1, 1'b0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_en1", en1, 1'b0);
        chk("rst_we1", mwe1, 1'b0);
        chk("rst_memrst1", mrst1, 1'b0);
        chk("rst_ready2", rdy2, 1'b0);
        chk("rst_en2", en2, 1'b0);

        @(negedge clka);
        rsta_n = 1'b1; v1 = 1'b0; we1 = 1'b0; v2 = 1'b0;
        #1;
        chk("rel_ready1", rdy1, 1'b1);
        chk("rel_ready2", rdy2, 1'b1);

        // Back-to-back reads 0..7, data equals address, consumer always ready
        for (int i = 0; i < 11; i++) begin
            drv1(i < 8, 1'b0, i, 0, 1'b1);
            chk("b2b_ready", rdy1, 1'b1);
            chk("b2b_valid", rv1, (i >= 2 && i < 10));
            if (i >= 2 && i < 10) chk("b2b_data", rd1, 64'(i - 2));
        end
        chk("b2b_idle", busy1, 1'b0);

        // Credit exhaustion with consumer stalled
        drv1(1, 0, 0, 0, 0); chk("cr_ready0", rdy1, 1'b1);
        drv1(1, 0, 1, 0, 0); chk("cr_ready1", rdy1, 1'b1);
        drv1(1, 0, 2, 0, 0); chk("cr_ready2", rdy1, 1'b1);
        chk("cr_head0", rd1, 16'd0);
        drv1(1, 0, 3, 0, 0); chk("cr_ready3", rdy1, 1'b1);
        drv1(1, 0, 4, 0, 0); chk("cr_full_ready", rdy1, 1'b0);
        chk("cr_full_en", en1, 1'b0);
        drv1(1, 0, 4, 0, 0); chk("cr_hold_ready", rdy1, 1'b0);
        chk("cr_busy", busy1, 1'b1);
        drv1(0, 0, 0, 0, 1); chk("cr_pop_valid", rv1, 1'b1);
        chk("cr_pop_data", rd1, 16'd0);
        drv1(1, 0, 4, 0, 0); chk("cr_credit_back", rdy1, 1'b1);
        chk("cr_head1", rd1, 16'd1);
        drv1(0, 0, 0, 0, 0); chk("cr_full_again", rdy1, 1'b0);

        // Full FIFO, then read fire and pop together; pointers wrap, order holds
        drv1(1, 0, 5, 0, 1); chk("wrap_blocked", en1, 1'b0);
        chk("wrap_d1", rd1, 16'd1);
        drv1(1, 0, 5, 0, 1); chk("wrap_rdy5", rdy1, 1'b1);
        chk("wrap_d2", rd1, 16'd2);
        drv1(1, 0, 6, 0, 1); chk("wrap_rdy6", rdy1, 1'b1);
        chk("wrap_d3", rd1, 16'd3);
        drv1(1, 0, 7, 0, 1); chk("wrap_rdy7", rdy1, 1'b1);
        chk("wrap_d4", rd1, 16'd4);
        drv1(0, 0, 0, 0, 1); chk("wrap_d5", rd1, 16'd5);
        drv1(0, 0, 0, 0, 1); chk("wrap_d6", rd1, 16'd6);
        drv1(0, 0, 0, 0, 1); chk("wrap_d7", rd1, 16'd7);
        chk("wrap_busy7", busy1, 1'b1);
        drv1(0, 0, 0, 0, 1); chk("wrap_empty", rv1, 1'b0);
        chk("wrap_idle", busy1, 1'b0);

        // Write 0xA5 to addr 3, read it back next cycle
        drv1(1, 1, 3, 'hA5, 0);
        chk("wr_en", en1, 1'b1);
        chk("wr_we", mwe1, 1'b1);
        chk("wr_addr", maddr1, 10'd3);
        chk("wr_din", din1, 16'h00A5);
        drv1(1, 0, 3, 0, 0);
        chk("rd_we", mwe1, 1'b0);
        chk("rd_en", en1, 1'b1);
        chk("wr_no_credit", busy1, 1'b0);
        drv1(0, 0, 0, 0, 0);
        chk("rd_c1_valid", rv1, 1'b0);
        chk("rd_c1_busy", busy1, 1'b1);
        drv1(0, 0, 0, 0, 1);
        chk("rd_c2_valid", rv1, 1'b1);
        chk("rd_c2_data", rd1, 16'h00A5);
        drv1(0, 0, 0, 0, 1);
        chk("rd_done_valid", rv1, 1'b0);
        chk("rd_done_busy", busy1, 1'b0);

        // Reset with one response queued and one read in the pipe
        drv1(1, 0, 0, 0, 0);
        drv1(1, 0, 1, 0, 0);
        chk("mid_busy_pre", busy1, 1'b1);
        @(negedge clka);
        rsta_n = 1'b0; v1 = 1'b0;
        #1;
        chk("mid_rst_valid", rv1, 1'b0);
        chk("mid_rst_busy", busy1, 1'b0);
        chk("mid_rst_ready", rdy1, 1'b0);
        @(negedge clka);
        rsta_n = 1'b1;
        #1;
        chk("mid_rel_ready", rdy1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drv1(0, 0, 0, 0, 1);
            chk("mid_no_stale", rv1, 1'b0);
            chk("mid_idle", busy1, 1'b0);
        end

        // Two-cycle latency read of addr 5
        drv2(1, 0, 5, 0, 1);
        chk("l2_ready", rdy2, 1'b1);
        chk("l2_en", en2, 1'b1);
        drv2(0, 0, 0, 0, 1);
        chk("l2_c1_valid", rv2, 1'b0);
        chk("l2_c1_busy", busy2, 1'b1);
        drv2(0, 0, 0, 0, 1);
        chk("l2_c2_valid", rv2, 1'b0);
        drv2(0, 0, 0, 0, 1);
        chk("l2_c3_valid", rv2, 1'b1);
        chk("l2_c3_data", rd2, 16'h003C);
        drv2(0, 0, 0, 0, 1);
        chk("l2_done_valid", rv2, 1'b0);
        chk("l2_done_busy", busy2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
